// File: rtl/guffin_coin_fsm_if.sv
// Coin/cancel inputs and one-hot state outputs of the guffin coin state engine.
// The slave modport is the state engine; the master side drives the acceptors.
interface guffin_coin_fsm_if;
    logic quarter_in;
    logic half_in;
    logic cancel_in;
    logic cState_0;
    logic cState_1;
    logic cState_2;
    logic cState_3;
    logic cState_4;
    logic cState_5;
    logic cState_6;
    logic busy;

    modport master (
        output quarter_in, half_in, cancel_in,
        input  cState_0, cState_1, cState_2, cState_3, cState_4, cState_5, cState_6, busy
    );

    modport slave (
        input  quarter_in, half_in, cancel_in,
        output cState_0, cState_1, cState_2, cState_3, cState_4, cState_5, cState_6, busy
    );
endinterface

// File: rtl/guffin_coin_fsm.sv
// Guffin vending upstream state engine: synchronizes coin/cancel inputs, accumulates
// credit toward 75 cents as a one-hot state, and holds vend/refund states for HOLD_CYCLES.
module guffin_coin_fsm #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    guffin_coin_fsm_if.slave   bus
);

    localparam logic [6:0] ST_S0 = 7'b0000001;
    localparam logic [6:0] ST_S1 = 7'b0000010;
    localparam logic [6:0] ST_S2 = 7'b0000100;
    localparam logic [6:0] ST_S3 = 7'b0001000;
    localparam logic [6:0] ST_S4 = 7'b0010000;
    localparam logic [6:0] ST_S5 = 7'b0100000;
    localparam logic [6:0] ST_S6 = 7'b1000000;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    localparam int CH_QUARTER = 0;
    localparam int CH_HALF    = 1;
    localparam int CH_CANCEL  = 2;

    logic [2:0] raw_in;
    logic [2:0] event_vec;
    logic [1:0] primed_reg;

    logic [6:0] state_reg;
    logic [6:0] state_next;
    logic [7:0] hold_cnt_reg;
    logic [7:0] hold_cnt_next;

    logic [6:0] state_out;
    logic       busy_out;

    assign raw_in[CH_QUARTER] = bus.quarter_in;
    assign raw_in[CH_HALF]    = bus.half_in;
    assign raw_in[CH_CANCEL]  = bus.cancel_in;

    // primed_reg[1] goes high once sync2 reflects real post-reset input levels; until then
    // the prev flops stay at 1 so a level already high during reset is never seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            primed_reg <= 2'b00;
        end else begin
            primed_reg <= {primed_reg[0], 1'b1};
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic sync1_reg;
            logic sync2_reg;
            logic prev_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    prev_reg  <= 1'b1;
                end else begin
                    sync1_reg <= raw_in[gi];
                    sync2_reg <= sync1_reg;
                    prev_reg  <= primed_reg[1] ? sync2_reg : prev_reg;
                end
            end

            assign event_vec[gi] = sync2_reg & ~prev_reg;
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_S0;
            hold_cnt_reg <= 8'd0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    // Next-state logic: cancel beats half, half beats quarter; all events ignored while holding.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            ST_S0: begin
                if (event_vec[CH_CANCEL]) begin
                    state_next = ST_S0;
                end else if (event_vec[CH_HALF]) begin
                    state_next = ST_S2;
                end else if (event_vec[CH_QUARTER]) begin
                    state_next = ST_S1;
                end
            end
            ST_S1: begin
                if (event_vec[CH_CANCEL]) begin
                    state_next    = ST_S5;
                    hold_cnt_next = HOLD_LOAD;
                end else if (event_vec[CH_HALF]) begin
                    state_next    = ST_S3;
                    hold_cnt_next = HOLD_LOAD;
                end else if (event_vec[CH_QUARTER]) begin
                    state_next = ST_S2;
                end
            end
            ST_S2: begin
                if (event_vec[CH_CANCEL]) begin
                    state_next    = ST_S6;
                    hold_cnt_next = HOLD_LOAD;
                end else if (event_vec[CH_HALF]) begin
                    state_next    = ST_S4;
                    hold_cnt_next = HOLD_LOAD;
                end else if (event_vec[CH_QUARTER]) begin
                    state_next    = ST_S3;
                    hold_cnt_next = HOLD_LOAD;
                end
            end
            ST_S3, ST_S4, ST_S5, ST_S6: begin
                if (hold_cnt_reg == 8'd0) begin
                    state_next    = ST_S0;
                    hold_cnt_next = 8'd0;
                end else begin
                    hold_cnt_next = hold_cnt_reg - 8'd1;
                end
            end
            default: begin
                state_next    = ST_S0;
                hold_cnt_next = 8'd0;
            end
        endcase
    end

    // Outputs come straight from the state flops
    always_comb begin
        state_out = state_reg;
        busy_out  = |state_reg[6:3];
    end

    assign bus.cState_0 = state_out[0];
    assign bus.cState_1 = state_out[1];
    assign bus.cState_2 = state_out[2];
    assign bus.cState_3 = state_out[3];
    assign bus.cState_4 = state_out[4];
    assign bus.cState_5 = state_out[5];
    assign bus.cState_6 = state_out[6];
    assign bus.busy     = busy_out;

endmodule

// File: tb/tb_guffin_coin_fsm.sv
// Directed bench for guffin_coin_fsm with HOLD_CYCLES=4: coin sequences, cancel,
// simultaneous events, hold timing and reset during hold.
module tb_guffin_coin_fsm;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b0000010;
    localparam logic [6:0] S2 = 7'b0000100;
    localparam logic [6:0] S3 = 7'b0001000;
    localparam logic [6:0] S4 = 7'b0010000;
    localparam logic [6:0] S5 = 7'b0100000;
    localparam logic [6:0] S6 = 7'b1000000;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    guffin_coin_fsm_if dif ();

    guffin_coin_fsm #(.HOLD_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] cur_state();
        return {dif.cState_6, dif.cState_5, dif.cState_4, dif.cState_3,
                dif.cState_2, dif.cState_1, dif.cState_0};
    endfunction

    // Inputs change and outputs are sampled on the falling edge
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        dif.quarter_in = 1'b0;
        dif.half_in    = 1'b0;
        dif.cancel_in  = 1'b0;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(2);
    endtask

    // Raise the chosen inputs for 3 cycles; the state change lands on the third edge.
    task automatic pulse(input logic q, input logic h, input logic c);
        dif.quarter_in = q;
        dif.half_in    = h;
        dif.cancel_in  = c;
        step(3);
        dif.quarter_in = 1'b0;
        dif.half_in    = 1'b0;
        dif.cancel_in  = 1'b0;
        $display("pulse q=%0b h=%0b c=%0b -> state=%b busy=%0b", q, h, c, cur_state(), dif.busy);
    endtask

    task automatic test_reset();
        dif.quarter_in = 1'b1;
        dif.half_in    = 1'b0;
        dif.cancel_in  = 1'b0;
        reset = 1'b1;
        step(3);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            n_checks++;
            if (cur_state() !== S0 || dif.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_held_quarter cycle %0d: state=%b busy=%b required state=%b busy=0",
                         i, cur_state(), dif.busy, S0);
            end
        end
        dif.quarter_in = 1'b0;
        step(3);
        dif.quarter_in = 1'b1;
        step(2);
        n_checks++;
        if (cur_state() !== S0) begin
            n_fail++;
            $display("FAIL reset_latency_early: state=%b required=%b", cur_state(), S0);
        end
        step(1);
        n_checks++;
        if (cur_state() !== S1) begin
            n_fail++;
            $display("FAIL reset_latency_s1: state=%b required=%b", cur_state(), S1);
        end
        dif.quarter_in = 1'b0;
        $display("test_reset done state=%b", cur_state());
    endtask

    task automatic test_three_quarters();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (cur_state() !== S1) begin
            n_fail++;
            $display("FAIL qqq_first: state=%b required=%b", cur_state(), S1);
        end
        step(3);
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (cur_state() !== S2) begin
            n_fail++;
            $display("FAIL qqq_second: state=%b required=%b", cur_state(), S2);
        end
        step(3);
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(1);
            n_checks++;
            if (cur_state() !== S3 || dif.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL qqq_vend_hold cycle %0d: state=%b busy=%b required state=%b busy=1",
                         i, cur_state(), dif.busy, S3);
            end
        end
        step(1);
        n_checks++;
        if (cur_state() !== S0 || dif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL qqq_return_idle: state=%b busy=%b required state=%b busy=0",
                     cur_state(), dif.busy, S0);
        end
    endtask

    task automatic test_half_half();
        do_reset();
        pulse(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (cur_state() !== S2) begin
            n_fail++;
            $display("FAIL hh_first: state=%b required=%b", cur_state(), S2);
        end
        step(3);
        pulse(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (cur_state() !== S4 || dif.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL hh_change_entry: state=%b busy=%b required state=%b busy=1",
                     cur_state(), dif.busy, S4);
        end
        // Quarter inserted during the hold must be discarded
        dif.quarter_in = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step(1);
            if (i == 2) dif.quarter_in = 1'b0;
            n_checks++;
            if (cur_state() !== S4) begin
                n_fail++;
                $display("FAIL hh_change_hold cycle %0d: state=%b required=%b", i, cur_state(), S4);
            end
        end
        step(1);
        n_checks++;
        if (cur_state() !== S0) begin
            n_fail++;
            $display("FAIL hh_return_idle: state=%b required=%b", cur_state(), S0);
        end
        step(5);
        n_checks++;
        if (cur_state() !== S0) begin
            n_fail++;
            $display("FAIL hh_quarter_ignored: state=%b required=%b", cur_state(), S0);
        end
        $display("test_half_half done state=%b", cur_state());
    endtask

    task automatic test_cancel();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        step(3);
        pulse(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(1);
            n_checks++;
            if (cur_state() !== S5 || dif.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL cancel_refund25 cycle %0d: state=%b busy=%b required state=%b busy=1",
                         i, cur_state(), dif.busy, S5);
            end
        end
        step(1);
        n_checks++;
        if (cur_state() !== S0) begin
            n_fail++;
            $display("FAIL cancel_refund25_exit: state=%b required=%b", cur_state(), S0);
        end
        step(3);
        pulse(1'b0, 1'b1, 1'b0);
        step(3);
        pulse(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(1);
            n_checks++;
            if (cur_state() !== S6 || dif.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL cancel_refund50 cycle %0d: state=%b busy=%b required state=%b busy=1",
                         i, cur_state(), dif.busy, S6);
            end
        end
        step(1);
        n_checks++;
        if (cur_state() !== S0) begin
            n_fail++;
            $display("FAIL cancel_refund50_exit: state=%b required=%b", cur_state(), S0);
        end
        step(4);
        n_checks++;
        if (cur_state() !== S0) begin
            n_fail++;
            $display("FAIL cancel_quarter_dropped: state=%b required=%b", cur_state(), S0);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        step(3);
        pulse(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (cur_state() !== S3) begin
            n_fail++;
            $display("FAIL simul_from_s1: state=%b required=%b", cur_state(), S3);
        end
        step(4);
        n_checks++;
        if (cur_state() !== S0) begin
            n_fail++;
            $display("FAIL simul_vend_exit: state=%b required=%b", cur_state(), S0);
        end
        step(3);
        pulse(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (cur_state() !== S2) begin
            n_fail++;
            $display("FAIL simul_from_s0: state=%b required=%b", cur_state(), S2);
        end
        step(3);
    endtask

    task automatic test_reset_mid_hold();
        // Entered from S2 left by the previous task
        pulse(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (cur_state() !== S4) begin
            n_fail++;
            $display("FAIL midhold_entry: state=%b required=%b", cur_state(), S4);
        end
        step(1);
        reset = 1'b1;
        step(1);
        n_checks++;
        if (cur_state() !== S0 || dif.busy !== 1'b0 || dut.hold_cnt_reg !== 8'd0) begin
            n_fail++;
            $display("FAIL midhold_reset: state=%b busy=%b cnt=%0d required state=%b busy=0 cnt=0",
                     cur_state(), dif.busy, dut.hold_cnt_reg, S0);
        end
        reset = 1'b0;
        step(2);
        pulse(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (cur_state() !== S1) begin
            n_fail++;
            $display("FAIL midhold_next_quarter: state=%b required=%b", cur_state(), S1);
        end
        step(3);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        dif.quarter_in = 1'b0;
        dif.half_in    = 1'b0;
        dif.cancel_in  = 1'b0;
        test_reset();
        test_three_quarters();
        test_half_half();
        test_cancel();
        test_simultaneous();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
